// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - opcode constants, immediate-format tags and pipe state encoding
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_ZIMM = 3'd6
  } imm_type_e;

  // EMPTY: nothing presented; ONE: output register valid; TWO: output and skid valid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/imm_gen_decode.sv
// rtl/imm_gen_decode.sv - combinational instruction to {imm, tag, illegal}; CSR zimm under IMM_GEN_ZIMM_EN
module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic            illegal
);

  logic [31:0] imm32;

  // Build the 32-bit immediate already sign-extended within 32 bits (zimm has bit 31 clear)
  always_comb begin
    imm32    = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (instruction[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        imm32    = {{20{instruction[31]}}, instruction[31:20]};
        imm_type = IMM_I;
      end
      OPC_STORE: begin
        imm32    = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        imm32    = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
        imm_type = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32    = {instruction[31:12], 12'h000};
        imm_type = IMM_U;
      end
      OPC_JAL: begin
        imm32    = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
        imm_type = IMM_J;
      end
      OPC_OP: begin
        imm32 = '0;
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_ZIMM_EN
        if (instruction[14]) begin
          imm32    = {27'd0, instruction[19:15]};
          imm_type = IMM_ZIMM;
        end
`else
        imm32 = '0;
`endif
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Widen to XLEN by replicating bit 31; zimm stays zero-extended since its bit 31 is 0
  always_comb begin
    imm       = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with two-entry skid buffer; optional IMM_GEN_ZIMM_EN
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_out,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       imm_type,
  output logic             illegal,
  output logic [CNT_W-1:0] ill_count
);

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;
  logic            dec_illegal;

  state_e          state;
  imm_type_e       out_type;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_imm;
  imm_type_e       skid_type;
  logic            skid_illegal;

  logic accept;
  logic drain;

  imm_gen_decode #(.XLEN(XLEN)) u_decode (
    .instruction (instruction),
    .imm         (dec_imm),
    .imm_type    (dec_type),
    .illegal     (dec_illegal)
  );

  // A flushed cycle never accepts, so it neither stores nor counts
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = out_valid && out_ready;
  assign imm_type = out_type;

  // Occupancy FSM with registered handshake outputs and the saturating illegal counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_EMPTY;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
      instr_out    <= '0;
      imm_out      <= '0;
      out_type     <= IMM_NONE;
      illegal      <= 1'b0;
      skid_instr   <= '0;
      skid_imm     <= '0;
      skid_type    <= IMM_NONE;
      skid_illegal <= 1'b0;
      ill_count    <= '0;
    end else begin
      if (accept && dec_illegal && (ill_count != {CNT_W{1'b1}})) begin
        ill_count <= ill_count + CNT_W'(1);
      end
      if (flush) begin
        state     <= ST_EMPTY;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (accept) begin
              instr_out <= instruction;
              imm_out   <= dec_imm;
              out_type  <= dec_type;
              illegal   <= dec_illegal;
              out_valid <= 1'b1;
              state     <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (accept && !drain) begin
              skid_instr   <= instruction;
              skid_imm     <= dec_imm;
              skid_type    <= dec_type;
              skid_illegal <= dec_illegal;
              in_ready     <= 1'b0;
              state        <= ST_TWO;
            end else if (drain && !accept) begin
              out_valid <= 1'b0;
              state     <= ST_EMPTY;
            end else if (accept && drain) begin
              instr_out <= instruction;
              imm_out   <= dec_imm;
              out_type  <= dec_type;
              illegal   <= dec_illegal;
            end
          end
          ST_TWO: begin
            if (drain) begin
              instr_out <= skid_instr;
              imm_out   <= skid_imm;
              out_type  <= skid_type;
              illegal   <= skid_illegal;
              in_ready  <= 1'b1;
              state     <= ST_ONE;
            end
          end
          default: begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized and directed bench for imm_gen_pipe against a queue model
module tb_imm_gen_pipe;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instruction = '0;

  logic             in_ready, out_valid, illegal;
  logic [31:0]      instr_out, imm_out;
  logic [2:0]       imm_type;
  logic [CNT_W-1:0] ill_count;

  logic             in_ready64, out_valid64, illegal64;
  logic [31:0]      instr_out64;
  logic [63:0]      imm_out64;
  logic [2:0]       imm_type64;
  logic [CNT_W-1:0] ill_count64;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] ins;
    longint      imm;
    logic [2:0]  t;
    logic        il;
  } ent_t;

  ent_t             q[$];
  logic [CNT_W-1:0] mcnt = '0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .imm_out(imm_out), .imm_type(imm_type), .illegal(illegal),
    .ill_count(ill_count)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(CNT_W)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instruction(instruction), .out_valid(out_valid64), .out_ready(out_ready),
    .instr_out(instr_out64), .imm_out(imm_out64), .imm_type(imm_type64), .illegal(illegal64),
    .ill_count(ill_count64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference immediate as a signed integer value of the encoded fields
  function automatic void ref_dec(input logic [31:0] i, output longint v,
                                  output logic [2:0] t, output logic il);
    v = 0; t = 3'd0; il = 1'b0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: begin v = longint'($signed(i[31:20])); t = 3'd1; end
      7'h23: begin v = longint'($signed({i[31:25], i[11:7]})); t = 3'd2; end
      7'h63: begin v = 2 * longint'($signed({i[31], i[7], i[30:25], i[11:8]})); t = 3'd3; end
      7'h37, 7'h17: begin v = 4096 * longint'($signed(i[31:12])); t = 3'd4; end
      7'h6F: begin v = 2 * longint'($signed({i[31], i[19:12], i[20], i[30:21]})); t = 3'd5; end
      7'h33: ;
      7'h73: begin
`ifdef IMM_GEN_ZIMM_EN
        if (i[14]) begin v = longint'(i[19:15]); t = 3'd6; end
`endif
      end
      default: il = 1'b1;
    endcase
  endfunction

  // Model: FIFO of at most two decoded entries, ready whenever fewer than two are held
  always @(posedge clk) begin
    ent_t e;
    longint v;
    logic [2:0] t;
    logic il;
    logic acc;
    if (!rst_n) begin
      q.delete();
      mcnt <= '0;
    end else if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      ref_dec(instruction, v, t, il);
      e.ins = instruction; e.imm = v; e.t = t; e.il = il;
      if (acc && il && (mcnt != {CNT_W{1'b1}})) mcnt <= mcnt + 1'b1;
      if (q.size() == 0) begin
        if (acc) q.push_back(e);
      end else begin
        if (acc) q.push_back(e);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Compare every settled cycle out of reset
  always @(negedge clk) begin
    longint ev;
    if (rst_n) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("ill_count", ill_count, mcnt);
      chk("in_ready64", in_ready64, q.size() < 2);
      if (q.size() > 0) begin
        ev = q[0].imm;
        chk("instr_out", instr_out, q[0].ins);
        chk("imm_out", imm_out, ev[31:0]);
        chk("imm_out64", imm_out64, ev);
        chk("imm_type", imm_type, q[0].t);
        chk("illegal", illegal, q[0].il);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] ins);
    in_valid = 1'b1; instruction = ins; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11];
    logic [31:0] r;
    int k;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h7F};
    r = $urandom();
    k = $urandom_range(0, 11);
    if (k == 11) return r;
    return {r[31:7], ops[k]};
  endfunction

  initial begin
    #1;
    in_valid = 1'b1; instruction = 32'h0000007F; out_ready = 1'b0;
    rst_n = 1'b0;
    cyc(); cyc();
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst imm_out", imm_out, 0);
    chk("rst imm_type", imm_type, 0);
    chk("rst illegal", illegal, 0);
    chk("rst instr_out", instr_out, 0);
    chk("rst ill_count", ill_count, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    cyc();

    send_one(32'hFFF00093);
    chk("addi imm", imm_out, 32'hFFFFFFFF);
    chk("addi type", imm_type, 1);
    chk("addi illegal", illegal, 0);

    send_one(32'h800000B7);
    chk("lui64 imm", imm_out64, 64'hFFFFFFFF80000000);
    chk("lui32 imm", imm_out, 32'h80000000);
    chk("lui type", imm_type, 4);

    send_one(32'h123450B7);
    chk("lui2 imm", imm_out, 32'h12345000);

    send_one(32'hFE000EE3);
    chk("beq imm", imm_out, 32'hFFFFFFFC);
    chk("beq type", imm_type, 3);

    cyc();
    out_ready = 1'b0;
    in_valid = 1'b1; instruction = 32'h00100093;
    cyc();
    chk("bp ready1", in_ready, 1);
    instruction = 32'h00200093;
    cyc();
    chk("bp ready2", in_ready, 0);
    chk("bp hold1", imm_out, 1);
    instruction = 32'h00300093;
    cyc();
    chk("bp ready3", in_ready, 0);
    chk("bp hold1b", imm_out, 1);
    out_ready = 1'b1;
    cyc();
    chk("bp seq2", imm_out, 2);
    chk("bp ready4", in_ready, 1);
    cyc();
    chk("bp seq3", imm_out, 3);
    in_valid = 1'b0;
    cyc();
    chk("bp empty", out_valid, 0);

    send_one(32'h0000007F);
    chk("ill flag", illegal, 1);
    chk("ill imm", imm_out, 0);
    chk("ill count1", ill_count, 1);
    in_valid = 1'b1; flush = 1'b1;
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush valid", out_valid, 0);
    chk("flush count", ill_count, 1);

    send_one(32'h300AD073);
`ifdef IMM_GEN_ZIMM_EN
    chk("zimm imm", imm_out, 32'h15);
    chk("zimm type", imm_type, 6);
`else
    chk("zimm imm", imm_out, 0);
    chk("zimm type", imm_type, 0);
`endif
    chk("zimm illegal", illegal, 0);
    cyc();

    do_reset();
    chk("rst2 count", ill_count, 0);
    in_valid = 1'b1; instruction = 32'h0000007F; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    in_valid = 1'b0;
    cyc();
    chk("sat count", ill_count, 15);
    do_reset();
    cyc();

    for (int i = 0; i < 4000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 40) == 0);
      rst_n       = ($urandom_range(0, 300) != 0);
      instruction = rand_inst();
      cyc();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
